olp_result_reader: RTL and testbench

OLP_RESULT_READER -- requirements
Module: olp_result_reader

---
 rtl/olp_pkg.sv | 22 ++
 rtl/olp_result_ram.sv | 34 +++
 rtl/olp_result_reader.sv | 167 ++++++++++++++++
 tb/tb_olp_result_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/olp_pkg.sv
// ---------------------------------------------------------------------------
// olp_pkg
// Shared definitions for the overlap-processor result reader: field widths
// of a stored face entry, the window-size encodings and the reader FSM state.
// ---------------------------------------------------------------------------
package olp_pkg;
   localparam int FACE_POS_W = 21;
   localparam int SIZE_W     = 2;
   localparam int ENTRY_W    = SIZE_W + FACE_POS_W;

   // Window-size encodings carried in iSize / oSize (3 is reserved)
   localparam logic [SIZE_W-1:0] SIZE_23 = 2'd0;
   localparam logic [SIZE_W-1:0] SIZE_19 = 2'd1;
   localparam logic [SIZE_W-1:0] SIZE_17 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } olp_state_e;
endpackage

// File: rtl/olp_result_ram.sv
// ---------------------------------------------------------------------------
// olp_result_ram
// DEPTH x W result buffer: one write port, one synchronous read port with a
// read enable (read data holds while iRe is low).
// Ports:
//   iClk            clock
//   iWe/iWaddr/iWdata   write port
//   iRe/iRaddr      read request, data appears on oRdata after the edge
//   oRdata          registered read data
// ---------------------------------------------------------------------------
module olp_result_ram
   import olp_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int W     = ENTRY_W
) (
   input  logic          iClk,
   input  logic          iWe,
   input  logic [AW-1:0] iWaddr,
   input  logic [W-1:0]  iWdata,
   input  logic          iRe,
   input  logic [AW-1:0] iRaddr,
   output logic [W-1:0]  oRdata
);
   logic [W-1:0] mem_q [DEPTH];

   // Write-first: a read of the address being written returns the new word,
   // which lets the reader prefetch entry 0 in the same cycle it is stored.
   always_ff @(posedge iClk) begin
      if (iWe) mem_q[iWaddr] <= iWdata;
      if (iRe) oRdata <= (iWe && (iWaddr == iRaddr)) ? iWdata : mem_q[iRaddr];
   end
endmodule

// File: rtl/olp_result_reader.sv
// ---------------------------------------------------------------------------
// olp_result_reader
// Collects face results from the overlap processor into a buffer during a
// frame, then presents them one per cycle on a valid/accept interface.
// Ports:
//   iClk, iReset         clock, synchronous active-high reset
//   iSet                 clear buffer and start collecting a new frame
//   iOutput_ready, iSize, iFace_Pos   face result strobe and payload
//   iFinish              last face of the frame has been emitted
//   iRd_req              downstream accept (transfer = iRd_req & oData_valid)
//   oData_valid, oSize, oFace_Pos     presented entry
//   oCount, oOverflow    entries stored this frame / a face was dropped
//   oBusy, oDone         collecting or draining / all entries read
// ---------------------------------------------------------------------------
module olp_result_reader
   import olp_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                  iClk,
   input  logic                  iReset,
   input  logic                  iSet,
   input  logic                  iOutput_ready,
   input  logic [SIZE_W-1:0]     iSize,
   input  logic [FACE_POS_W-1:0] iFace_Pos,
   input  logic                  iFinish,
   input  logic                  iRd_req,
   output logic                  oData_valid,
   output logic [SIZE_W-1:0]     oSize,
   output logic [FACE_POS_W-1:0] oFace_Pos,
   output logic [CNT_W-1:0]      oCount,
   output logic                  oOverflow,
   output logic                  oBusy,
   output logic                  oDone
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   olp_state_e            state_q, state_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;   // next address to prefetch
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [SIZE_W-1:0]     size_q, size_d;
   logic [FACE_POS_W-1:0] pos_q, pos_d;

   logic                  ram_we;
   logic                  ram_re;
   logic [AW-1:0]         ram_raddr;
   logic [ENTRY_W-1:0]    ram_rdata;

   olp_result_ram #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_ram (
      .iClk   (iClk),
      .iWe    (ram_we),
      .iWaddr (wr_ptr_q),
      .iWdata ({iSize, iFace_Pos}),
      .iRe    (ram_re),
      .iRaddr (ram_raddr),
      .oRdata (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      valid_d   = valid_q;
      size_d    = size_q;
      pos_d     = pos_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_raddr = rd_ptr_q[AW-1:0];

      if (iSet) begin
         state_d  = ST_COLLECT;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         valid_d  = 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (iOutput_ready) begin
                  if (count_q != FULL) begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr_q + AW'(1);
                     count_d  = count_q + CNT_W'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               if (iFinish) begin
                  if (count_d != '0) begin
                     // Prefetch entry 0 now so it can be presented one
                     // cycle after entering DRAIN.
                     state_d  = ST_DRAIN;
                     ram_re   = 1'b1;
                     rd_ptr_d = rd_ptr_q + CNT_W'(1);
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DRAIN: begin
               // The RAM output always holds the entry after the presented
               // one, so the fetch pointer runs two ahead of the presented
               // index: the last entry is presented when it equals count+1.
               if (!valid_q || iRd_req) begin
                  if (valid_q && (rd_ptr_q == count_q + CNT_W'(1))) begin
                     valid_d = 1'b0;
                     state_d = ST_DONE;
                  end else begin
                     valid_d           = 1'b1;
                     {size_d, pos_d}   = ram_rdata;
                     ram_re            = 1'b1;
                     rd_ptr_d          = rd_ptr_q + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         size_q   <= '0;
         pos_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         size_q   <= size_d;
         pos_q    <= pos_d;
      end
   end

   assign oData_valid = valid_q;
   assign oSize       = size_q;
   assign oFace_Pos   = pos_q;
   assign oCount      = count_q;
   assign oOverflow   = ovf_q;
   assign oBusy       = busy_q;
   assign oDone       = done_q;
endmodule

// File: tb/tb_olp_result_reader.sv
// ---------------------------------------------------------------------------
// tb_olp_result_reader
// Drives olp_result_reader with directed and random frames. A frame-level
// reference model predicts which faces are kept, the count, overflow and
// phase; kept faces go into an expected queue that a negedge monitor pops
// as the DUT hands entries over.
// ---------------------------------------------------------------------------
module tb_olp_result_reader;
   import olp_pkg::*;

   localparam int DEPTH = 32;
   localparam int CNT_W = 6;

   localparam int P_IDLE  = 0;
   localparam int P_COLL  = 1;
   localparam int P_FIRST = 2;   // finish seen, first entry not yet shown
   localparam int P_DRAIN = 3;
   localparam int P_DONE  = 4;

   logic                  iClk = 1'b0;
   logic                  iReset = 1'b0;
   logic                  iSet = 1'b0;
   logic                  iOutput_ready = 1'b0;
   logic [SIZE_W-1:0]     iSize = '0;
   logic [FACE_POS_W-1:0] iFace_Pos = '0;
   logic                  iFinish = 1'b0;
   logic                  iRd_req = 1'b0;
   logic                  oData_valid;
   logic [SIZE_W-1:0]     oSize;
   logic [FACE_POS_W-1:0] oFace_Pos;
   logic [CNT_W-1:0]      oCount;
   logic                  oOverflow;
   logic                  oBusy;
   logic                  oDone;

   olp_result_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .iClk          (iClk),
      .iReset        (iReset),
      .iSet          (iSet),
      .iOutput_ready (iOutput_ready),
      .iSize         (iSize),
      .iFace_Pos     (iFace_Pos),
      .iFinish       (iFinish),
      .iRd_req       (iRd_req),
      .oData_valid   (oData_valid),
      .oSize         (oSize),
      .oFace_Pos     (oFace_Pos),
      .oCount        (oCount),
      .oOverflow     (oOverflow),
      .oBusy         (oBusy),
      .oDone         (oDone)
   );

   always #5 iClk = ~iClk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model
   logic [ENTRY_W-1:0] exp_q [$];
   int m_phase = P_IDLE;
   int m_cnt   = 0;
   int m_left  = 0;
   bit m_ovf   = 1'b0;
   bit m_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit set, input bit ordy,
                             input logic [SIZE_W-1:0] sz, input logic [FACE_POS_W-1:0] pos,
                             input bit fin, input bit rd);
      if (rst || set) begin
         m_phase = rst ? P_IDLE : P_COLL;
         exp_q.delete();
         m_cnt   = 0;
         m_left  = 0;
         m_ovf   = 1'b0;
         m_valid = 1'b0;
      end else begin
         case (m_phase)
            P_COLL: begin
               if (ordy) begin
                  if (m_cnt < DEPTH) begin
                     exp_q.push_back({sz, pos});
                     m_cnt++;
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
               if (fin) begin
                  m_left  = m_cnt;
                  m_phase = (m_cnt > 0) ? P_FIRST : P_DONE;
               end
            end
            P_FIRST: begin
               m_valid = 1'b1;
               m_phase = P_DRAIN;
            end
            P_DRAIN: begin
               if (rd) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_valid = 1'b0;
                     m_phase = P_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic step(input bit rst, input bit set, input bit ordy,
                       input logic [SIZE_W-1:0] sz, input logic [FACE_POS_W-1:0] pos,
                       input bit fin, input bit rd);
      iReset = rst; iSet = set; iOutput_ready = ordy; iSize = sz;
      iFace_Pos = pos; iFinish = fin; iRd_req = rd;
      @(posedge iClk);
      model_edge(rst, set, ordy, sz, pos, fin, rd);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 2'($urandom_range(0, 2)), 21'($urandom), 0, 0);
   endtask

   task automatic face(input logic [SIZE_W-1:0] sz, input logic [FACE_POS_W-1:0] pos, input bit fin);
      step(0, 0, 1, sz, pos, fin, 0);
   endtask

   task automatic rand_face(input bit fin);
      face(2'($urandom_range(0, 2)), 21'($urandom), fin);
   endtask

   // Drain with accept probability pct; noise on ordy/finish must be ignored.
   task automatic drain(input int pct, input int max_cyc);
      int c;
      c = 0;
      while (m_phase != P_DONE && c < max_cyc) begin
         step(0, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 21'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 99)) < pct);
         c++;
      end
   endtask

   // Monitor: compares every cycle; the presented entry must be the front of
   // the expected queue, and an accepted entry is popped.
   always @(negedge iClk) begin
      if (chk_en) begin
         chk("valid", 32'(oData_valid), 32'(m_valid));
         chk("count", 32'(oCount), 32'(m_cnt));
         chk("overflow", 32'(oOverflow), 32'(m_ovf));
         chk("busy", 32'(oBusy), 32'(m_phase == P_COLL || m_phase == P_FIRST || m_phase == P_DRAIN));
         chk("done", 32'(oDone), 32'(m_phase == P_DONE));
         if (oData_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL data at %0t: got %0h expected none", $time, {oSize, oFace_Pos});
            end else begin
               chk("data", 32'({oSize, oFace_Pos}), 32'(exp_q[0]));
               if (iRd_req) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      bit fin_done;

      // reset
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      chk("rst_size", 32'(oSize), 32'd0);
      chk("rst_pos", 32'(oFace_Pos), 32'd0);
      idle(2);

      // basic frame
      step(0, 1, 0, 0, 0, 0, 0);
      face(SIZE_23, 21'h00001, 0);
      face(SIZE_19, 21'h0ABCD, 0);
      face(SIZE_17, 21'h1FFFF, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      drain(100, 20);
      idle(2);

      // overflow
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 34; i++) rand_face(0);
      step(0, 0, 0, 0, 0, 1, 0);
      drain(100, 60);
      idle(1);

      // empty frame, then ignored inputs in DONE
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      rand_face(1);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // finish coincident with the 5th face
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) rand_face(0);
      rand_face(1);
      drain(100, 20);

      // backpressure 1,0,0,1
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) rand_face(0);
      step(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      drain(100, 20);

      // abort mid-drain after 2 of 4 reads, then reset coincident with set
      step(0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) rand_face(0);
      step(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 2'd1, 21'h12345, 1, 1);
      rand_face(0);
      step(1, 1, 0, 0, 0, 0, 0);
      rand_face(1);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1);

      // random frames; an unfinished drain is aborted by the next iSet
      for (int f = 0; f < 30; f++) begin
         n = $urandom_range(0, 40);
         fin_done = 1'b0;
         step(0, 1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            if (k == n - 1 && $urandom_range(0, 1) == 1) begin
               rand_face(1);
               fin_done = 1'b1;
            end else begin
               rand_face(0);
            end
         end
         if (!fin_done) step(0, 0, 0, 0, 0, 1, 0);
         if ($urandom_range(0, 3) == 0) drain(int'($urandom_range(20, 100)), int'($urandom_range(1, 10)));
         else drain(int'($urandom_range(30, 100)), 400);
         idle(1);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
